// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - register offsets, CTRL field layout and hex-to-7seg lookup for mmio_io_ctrl
package io_pkg;

   localparam logic [7:0] IO_STATUS  = 8'h00;
   localparam logic [7:0] IO_SWITCH  = 8'h04;
   localparam logic [7:0] IO_DISPLAY = 8'h08;
   localparam logic [7:0] IO_CTRL    = 8'h0C;

   typedef struct packed {
      logic [7:0] digit_mask;
      logic       disp_en;
   } io_ctrl_t;

   // Active-low segments, bit6=a .. bit0=g.
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - 2-flop synchroniser plus stable-count debouncer for one button
module io_debounce #(
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt;
   logic             accept;

   // The DEBOUNCE_CYCLES-th consecutive differing cycle commits the new level.
   assign accept = (sync_q[1] != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
   assign rise   = accept && sync_q[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         cnt    <= '0;
         level  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw};
         if (sync_q[1] == level) begin
            cnt <= '0;
         end else if (accept) begin
            cnt   <= '0;
            level <= sync_q[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mmio_io_ctrl.sv
// rtl/mmio_io_ctrl.sv - MMIO buttons/switches/7-seg peripheral; IO_LEADING_ZERO_BLANK_EN blanks leading zero digits
module mmio_io_ctrl
   import io_pkg::*;
#(
   parameter int NUM_DIGITS      = 8,
   parameter int NUM_BTNS        = 2,
   parameter int SW_W            = 16,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int SCAN_DIV        = 100000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            addr,
   input  logic                  we,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   input  logic [NUM_BTNS-1:0]   btn,
   input  logic [SW_W-1:0]       sw,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            a2g
);

   localparam int PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int MASK_INT = (1 << NUM_DIGITS) - 1;
   localparam logic [7:0] MASK_ALL = MASK_INT[7:0];

   logic [NUM_BTNS-1:0]     btn_level, btn_rise, pending, clr;
   logic [SW_W-1:0]         sw_m, sw_s;
   logic [4*NUM_DIGITS-1:0] display;
   io_ctrl_t                ctrl;
   logic [PRE_W-1:0]        pre;
   logic [IDX_W-1:0]        idx;
   logic [NUM_DIGITS-1:0]   lit, an_d;
   logic [3:0]              cur_nib;

   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
      io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .reset (reset),
         .raw   (btn[g]),
         .level (btn_level[g]),
         .rise  (btn_rise[g])
      );
   end

   assign clr = (we && addr == IO_STATUS) ? wdata[NUM_BTNS-1:0] : '0;

   // Set is OR-ed in after the clear so a same-cycle event is never lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_m    <= '0;
         sw_s    <= '0;
         pending <= '0;
         display <= '0;
         ctrl    <= '{digit_mask: MASK_ALL, disp_en: 1'b1};
      end else begin
         sw_m    <= sw;
         sw_s    <= sw_m;
         pending <= (pending & ~clr) | btn_rise;
         if (we && addr == IO_DISPLAY)
            display <= wdata[4*NUM_DIGITS-1:0];
         if (we && addr == IO_CTRL) begin
            ctrl.disp_en    <= wdata[0];
            ctrl.digit_mask <= wdata[15:8] & MASK_ALL;
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         IO_STATUS: begin
            rdata[NUM_BTNS-1:0]  = pending;
            rdata[8 +: NUM_BTNS] = btn_level;
         end
         IO_SWITCH:  rdata = 32'(sw_s);
         IO_DISPLAY: rdata = 32'(display);
         IO_CTRL: begin
            rdata[0]    = ctrl.disp_en;
            rdata[15:8] = ctrl.digit_mask;
         end
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre <= '0;
         idx <= '0;
      end else if (pre == PRE_W'(SCAN_DIV - 1)) begin
         pre <= '0;
         idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         pre <= pre + 1'b1;
      end
   end

`ifdef IO_LEADING_ZERO_BLANK_EN
   always_comb begin
      logic seen;
      seen = 1'b0;
      lit  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         seen   = seen | (|display[4*i +: 4]);
         lit[i] = seen || (i == 0);
      end
   end
`else
   assign lit = '1;
`endif

   always_comb begin
      cur_nib = '0;
      an_d    = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nib = display[4*i +: 4];
            an_d[i] = ~(ctrl.disp_en & ctrl.digit_mask[i] & lit[i]);
         end
      end
   end

   // Pin outputs are registered so an stays all-ones for the whole reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an  <= '1;
         a2g <= 7'b0000001;
      end else begin
         an  <= an_d;
         a2g <= seg7(cur_nib);
      end
   end

endmodule
